// File: rtl/demux_1to4_tdm.sv
// rtl/demux_1to4_tdm.sv - 1-to-4 time-division demultiplexer with frame sync
//
// Collects serial slot bits into a shadow register and publishes each
// complete frame on q in parallel. DEMUX_PARITY_EN adds a fifth, even-parity
// slot; a frame whose parity check fails is dropped and flagged.
//
// Ports:
//   clk         - rising-edge clock
//   resetn      - asynchronous active-low reset
//   en          - slot strobe; d_in and sync are sampled only when high
//   d_in        - serial data bit for the current slot
//   sync        - frame marker; the bit on d_in with sync is slot 0
//   q[3:0]      - last accepted frame, q[i] = slot i
//   frame_valid - one-cycle pulse, q updated on the same edge
//   sync_err    - one-cycle pulse, partial frame aborted by an early sync
//   slot[2:0]   - index of the next slot to be captured
//   locked      - high while the framer is in RUN
//   parity_err  - one-cycle pulse on parity failure (0 without DEMUX_PARITY_EN)

module demux_1to4_tdm (
   input  logic       clk,
   input  logic       resetn,
   input  logic       en,
   input  logic       d_in,
   input  logic       sync,
   output logic [3:0] q,
   output logic       frame_valid,
   output logic       sync_err,
   output logic [2:0] slot,
   output logic       locked,
   output logic       parity_err
);

`ifdef DEMUX_PARITY_EN
   localparam logic [2:0] LAST_SLOT = 3'd4;
`else
   localparam logic [2:0] LAST_SLOT = 3'd3;
`endif
   // The last slot is taken straight from d_in, so only earlier slots need storage.
   localparam int SW = int'(LAST_SLOT);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state, state_n;
   logic [2:0]      slot_n;
   logic [SW-1:0]   shadow, shadow_n;
   logic [3:0]      q_n;
   logic            fv_n, se_n;
`ifdef DEMUX_PARITY_EN
   logic            pe_n;
   logic            pe_q;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         slot        <= 3'd0;
         shadow      <= '0;
         q           <= 4'b0000;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
`ifdef DEMUX_PARITY_EN
         pe_q        <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         slot        <= slot_n;
         shadow      <= shadow_n;
         q           <= q_n;
         frame_valid <= fv_n;
         sync_err    <= se_n;
`ifdef DEMUX_PARITY_EN
         pe_q        <= pe_n;
`endif
      end
   end

   always_comb begin
      state_n  = state;
      slot_n   = slot;
      shadow_n = shadow;
      q_n      = q;
      fv_n     = 1'b0;
      se_n     = 1'b0;
`ifdef DEMUX_PARITY_EN
      pe_n     = 1'b0;
`endif
      if (en) begin
         if (state == IDLE) begin
            if (sync) begin
               shadow_n = {{(SW-1){1'b0}}, d_in};
               slot_n   = 3'd1;
               state_n  = RUN;
            end
         end else if (sync && (slot != 3'd0)) begin
            // Early sync: drop the partial frame and restart at slot 0.
            se_n     = 1'b1;
            shadow_n = {{(SW-1){1'b0}}, d_in};
            slot_n   = 3'd1;
         end else if (slot == LAST_SLOT) begin
            slot_n = 3'd0;
`ifdef DEMUX_PARITY_EN
            if ((^{d_in, shadow}) == 1'b0) begin
               q_n  = shadow;
               fv_n = 1'b1;
            end else begin
               pe_n = 1'b1;
            end
`else
            q_n  = {d_in, shadow};
            fv_n = 1'b1;
`endif
         end else begin
            for (int i = 0; i < SW; i++) begin
               if (slot == 3'(i)) shadow_n[i] = d_in;
            end
            slot_n = slot + 3'd1;
         end
      end
   end

   assign locked = (state == RUN);

`ifdef DEMUX_PARITY_EN
   assign parity_err = pe_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule
